// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared definitions for the front-end pipeline stages.
//   XLEN      : default address/instruction width
//   NOP_INSTR : bubble encoding (addi x0,x0,0)
//   RESET_PC  : default PC loaded on reset
//   skid_state_e : state of the one-entry fetch skid buffer
//   if_id_t   : architectural view of the IF/ID register {pc, instr, valid}
// ---------------------------------------------------------------------------
package riscv_pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // RUN: skid empty, HELD: skid holds one returned instruction
  typedef enum logic [0:0] {
    SKID_RUN  = 1'b0,
    SKID_HELD = 1'b1
  } skid_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// ---------------------------------------------------------------------------
// if_skid_buf
// One-entry holding register for an instruction that returned from the
// instruction memory while the IF/ID register was not allowed to load.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   capture_i   : store {pc_i, instr_i}; only honoured while empty
//   drain_i     : consumer takes the entry this cycle (ignored while empty)
//   clear_i     : discard the entry (flush / redirect)
//   pc_i/instr_i: entry contents to capture
//   full_o      : entry holds a valid instruction
//   pc_o/instr_o: stored entry
// ---------------------------------------------------------------------------
module if_skid_buf #(
  parameter int unsigned XLEN = riscv_pipe_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);
  import riscv_pipe_pkg::*;

  skid_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, instr_q;
  logic            load_s;

  // Data is written only on the RUN->HELD transition so a held entry is never overwritten
  assign load_s = (state_q == SKID_RUN) & capture_i;

  // Next-state logic for the skid occupancy
  always_comb begin
    state_d = state_q;
    case (state_q)
      SKID_RUN: begin
        if (capture_i) state_d = SKID_HELD;
        else           state_d = SKID_RUN;
      end
      SKID_HELD: begin
        if (drain_i || clear_i) state_d = SKID_RUN;
        else                    state_d = SKID_HELD;
      end
      default: state_d = SKID_RUN;
    endcase
  end

  // State and payload registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SKID_RUN;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_s) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end else begin
        pc_q    <= pc_q;
        instr_q <= instr_q;
      end
    end
  end

  assign full_o  = (state_q == SKID_HELD);
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage_pipe.sv
// ---------------------------------------------------------------------------
// if_stage_pipe
// Instruction-fetch stage: PC register, synchronous imem request/response
// tracking, one-entry skid buffer and the IF/ID pipeline register. Applies
// the hazard unit's PCWrite / IF_ID_Hold (active-low hold) / IF_ID_Flush
// controls and ID-stage redirects without losing or duplicating fetches.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   PCWrite           : PC may advance
//   IF_ID_Hold        : 1 = IF/ID loads, 0 = IF/ID keeps contents
//   IF_ID_Flush       : IF/ID loads a bubble
//   redirect_valid/pc : taken branch/jump target from ID
//   imem_req/addr     : fetch request (addr = pc_q)
//   imem_rdata        : read data, valid the cycle after imem_req
//   IF_ID_PC/Instr/Valid : IF/ID register contents
// Optional build macro IF_STAGE_PERF_EN adds saturating counters
//   perf_stall_cnt (cycles with IF_ID_Hold=0) and perf_flush_cnt
//   (cycles with IF_ID_Flush=1).
// ---------------------------------------------------------------------------
module if_stage_pipe #(
  parameter int unsigned    XLEN      = riscv_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pipe_pkg::RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(riscv_pipe_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCWrite,
  input  logic            IF_ID_Hold,
  input  logic            IF_ID_Flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_Instr,
  output logic            IF_ID_Valid
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);
  import riscv_pipe_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            rsp_v_q, rsp_v_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;

  logic            req_s;
  logic            rsp_live_s;
  logic            skid_full_s;
  logic            skid_capture_s;
  logic            skid_drain_s;
  logic            skid_clear_s;
  logic [XLEN-1:0] skid_pc_s, skid_instr_s;

  // rst_n gating keeps the memory quiet during reset
  assign req_s     = rst_n & PCWrite & IF_ID_Hold & ~redirect_valid;
  assign imem_req  = req_s;
  assign imem_addr = pc_q;

  // A response coinciding with a redirect belongs to the wrong path
  assign rsp_live_s = rsp_v_q & ~redirect_valid;

  // Park a live response when IF/ID cannot take it; a flush drops it instead
  assign skid_capture_s = rsp_live_s & ~IF_ID_Hold & ~IF_ID_Flush;
  assign skid_drain_s   = IF_ID_Hold & ~IF_ID_Flush & ~redirect_valid;
  assign skid_clear_s   = IF_ID_Flush | redirect_valid;

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (skid_capture_s),
    .drain_i   (skid_drain_s),
    .clear_i   (skid_clear_s),
    .pc_i      (rsp_pc_q),
    .instr_i   (imem_rdata),
    .full_o    (skid_full_s),
    .pc_o      (skid_pc_s),
    .instr_o   (skid_instr_s)
  );

  // PC next-state (redirect overrides PCWrite) and response tracking
  always_comb begin
    pc_d     = pc_q;
    rsp_v_d  = req_s;
    rsp_pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req_s) begin
      pc_d = pc_q + XLEN'(32'd4);
    end else begin
      pc_d = pc_q;
    end
  end

  // IF/ID next-state: flush > hold > skid > live response > bubble
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (IF_ID_Flush) begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (!IF_ID_Hold) begin
      if_id_valid_d = if_id_valid_q;
    end else if (skid_full_s && !redirect_valid) begin
      if_id_pc_d    = skid_pc_s;
      if_id_instr_d = skid_instr_s;
      if_id_valid_d = 1'b1;
    end else if (rsp_live_s) begin
      if_id_pc_d    = rsp_pc_q;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
    end else begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end
  end

  // PC, response tracker and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_v_q       <= 1'b0;
      rsp_pc_q      <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rsp_v_q       <= rsp_v_d;
      rsp_pc_q      <= rsp_pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign IF_ID_PC    = if_id_pc_q;
  assign IF_ID_Instr = if_id_instr_q;
  assign IF_ID_Valid = if_id_valid_q;

`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (!IF_ID_Hold && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      else                                                  perf_stall_q <= perf_stall_q;
      if (IF_ID_Flush && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
      else                                                  perf_flush_q <= perf_flush_q;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/if_stage_pipe.md
# if_stage_pipe

Instruction-fetch stage with PC register, synchronous instruction-memory request/response tracking, and the IF/ID pipeline register. It is the consumer of the stall/flush controls (`PCWrite`, `IF_ID_Hold`, `IF_ID_Flush`) produced by the hazard detection unit. It applies those controls cycle-accurately. It holds at most one returned instruction in a skid entry, so no fetched instruction is lost or duplicated under stall, flush or redirect.

## Interface
Parameters:
- `XLEN`, 32, address/instruction width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `PCWrite`  in  1  1 = PC may advance; 0 = freeze PC
- `IF_ID_Hold`  in  1  active-low hold; 1 = IF/ID loads; 0 = IF/ID keeps contents
- `IF_ID_Flush`  in  1  1 = IF/ID loads bubble
- `redirect_valid`  in  1  taken branch/jump resolved in ID
- `redirect_pc`  in  XLEN  redirect target
- `imem_req`  out  1  fetch request this cycle
- `imem_addr`  out  XLEN  fetch address (= `pc_q`)
- `imem_rdata`  in  XLEN  read data, valid the cycle after `imem_req`
- `IF_ID_PC`  out  XLEN  PC of instruction in IF/ID
- `IF_ID_Instr`  out  XLEN  instruction in IF/ID
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction

## Operation
- **Request generation.** `imem_req = PCWrite & IF_ID_Hold & ~redirect_valid`. `imem_addr = pc_q`.
- **PC next-state.** Priority order:
  - `redirect_valid` → `redirect_pc`, regardless of `PCWrite`.
  - else `imem_req` → `pc_q + 4`, modulo 2^XLEN, wraps silently.
  - else hold.
- **Response tracking.**
  - `rsp_v_q <= imem_req & ~redirect_valid` and `rsp_pc_q <= pc_q`.
  - A response present in a cycle with `redirect_valid=1` is wrong-path and is dropped.
- **Skid entry.** States RUN (empty) and HELD (full).
  - RUN→HELD: `rsp_v_q & ~IF_ID_Hold & ~IF_ID_Flush & ~redirect_valid`; captures `{rsp_pc_q, imem_rdata}`.
  - HELD→RUN: IF/ID loads from skid, or `IF_ID_Flush`, or `redirect_valid` (entry discarded).
  - Invariant: no response can arrive while HELD, because `imem_req` was 0 in the previous cycle. A bench assertion must check this.
- **IF/ID update.** Priority order:
  - `IF_ID_Flush` → `Instr=NOP_INSTR`, `Valid=0`, PC unchanged.
  - `IF_ID_Hold=0` → keep contents.
  - else load the skid if HELD, the response if `rsp_v_q & ~redirect_valid`, otherwise a bubble (`NOP_INSTR`, `Valid=0`).
- **Simultaneous events.**
  - Flush together with hold=0: flush wins.
  - Redirect together with a response: the response is dropped; IF/ID is governed by flush/hold only.
- **Reset** (synchronous, `rst_n=0` at the edge), mid-operation included:
  - `pc_q=RESET_PC`; `rsp_v_q=0`; skid RUN.
  - `IF_ID_PC=0`, `IF_ID_Instr=NOP_INSTR`, `IF_ID_Valid=0`.
  - `imem_req` forced 0 while `rst_n=0`.
  - An in-flight response is discarded.

## Timing
- Cycle 0 is the first cycle with `rst_n=1`: `imem_req=1`, addr `RESET_PC`.
  - Data returns in cycle 1.
  - `IF_ID_Valid=1` with PC `RESET_PC` from cycle 2.
- Steady state: one instruction per cycle; fetch-to-IF/ID latency of 2 edges.
- Redirect in cycle N:
  - `pc_q=target` in N+1 with request.
  - Target in IF/ID from N+3, given a flush in N as the hazard unit issues.
- Stall (`PCWrite=0`, `IF_ID_Hold=0`) in cycles N..N+k: PC frozen, IF/ID frozen, in-flight instruction parked in skid.
  - First cycle with hold=1: skid enters IF/ID at that edge.
  - New request in the same cycle; no gap bubble.
- Flush: bubble visible the cycle after `IF_ID_Flush`.

## Configuration
- `IF_STAGE_PERF_EN` defined: adds outputs `perf_stall_cnt` (32, cycles with `IF_ID_Hold=0`) and `perf_flush_cnt` (32, cycles with `IF_ID_Flush=1`).
  - Both saturate at all-ones and reset to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `riscv_pipe_pkg`: `XLEN`, `NOP_INSTR`, default `RESET_PC`, and a typedef `if_id_t` {pc, instr, valid}.
- One sub-module `if_skid_buf`: a one-entry register with capture/drain/clear inputs, and full, pc and instr outputs.

## Test plan
- **Reset release**, imem returning `addr^32'hA5A5_0000` → IF/ID shows PCs 0,4,8 with matching instr on cycles 2,3,4; `Valid=1`.
- **3-cycle stall** (`PCWrite=0`, `IF_ID_Hold=0`) while PC=0x10 in flight → IF/ID frozen at 0x0C.
  - After release: 0x10, then 0x14, on consecutive cycles.
  - No duplicates or skips.
- **Redirect to 0x200** with flush in the same cycle as a response → bubble (`Valid=0`, `NOP_INSTR`).
  - Wrong-path PC never appears.
  - 0x200 valid two cycles later.
- **Flush together with `IF_ID_Hold=0`** while HELD → bubble loaded, skid cleared, `imem_req=0` that cycle.
- **`rst_n=0` for one cycle mid-stream** with the skid full → all outputs at reset values.
  - The next fetch is `RESET_PC`.
  - Parked instruction lost.
- **Wrap-around** at `pc_q=32'hFFFF_FFFC` → next `imem_addr=0`.
  - With `IF_STAGE_PERF_EN`: 5 stall cycles give `perf_stall_cnt=5`.
